// File: rtl/fifo_sync_param_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Optional error flags are enabled by defining FIFO_SYNC_ERR_FLAGS_EN.
package fifo_pkg;

  // Occupancy condition; 2'b01 is never produced.
  typedef enum logic [1:0] {
    COND_EMPTY   = 2'b00,
    COND_PARTIAL = 2'b10,
    COND_FULL    = 2'b11
  } cond_t;

  // Pointer width for a given depth; at least one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Bus bundle between the FIFO and its producer/consumer.
// Handshake: a write is taken on a rising edge when write=1 and the FIFO is not
// full (or is full and a read is taken in the same cycle); a read is taken when
// read=1 and the FIFO is not empty. A taken read returns its word one cycle
// later with read_stb=1; dout holds its value whenever read_stb=0.
// FIFO_SYNC_ERR_FLAGS_EN adds err_clr, overflow and underflow.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] din;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] dout;
  logic             read_stb;
  logic [1:0]       condition;
  logic [LW-1:0]    level;
  logic             almost_full;
  logic             almost_empty;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output din, write, read, err_clr,
    input  dout, read_stb, condition, level, almost_full, almost_empty,
           overflow, underflow
  );
  modport slave (
    input  din, write, read, err_clr,
    output dout, read_stb, condition, level, almost_full, almost_empty,
           overflow, underflow
  );
`else
  modport master (
    output din, write, read,
    input  dout, read_stb, condition, level, almost_full, almost_empty
  );
  modport slave (
    input  din, write, read,
    output dout, read_stb, condition, level, almost_full, almost_empty
  );
`endif
endinterface

// File: rtl/fifo_sync_param_ram.sv
// Simple dual-port storage array with a registered read port.
// The array itself is never reset; only the read data register clears.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: store incoming word at the write address.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port: capture the addressed word (old value on a same-address write).
  always_ff @(posedge clk) begin
    if (rst)       rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, level, flags and read strobe.
// Optional sticky error flags are enabled by defining FIFO_SYNC_ERR_FLAGS_EN.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic clk,
  input  logic rst,
  fifo_sync_param_if.slave bus
);
  localparam int AW = ptr_width(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must not exceed DEPTH");
  end
  if (AE_LEVEL >= DEPTH) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be below DEPTH");
  end

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [LW-1:0] level_q, level_d;
  logic          stb_q, stb_d;
  logic          rd_acc, wr_acc;
  cond_t         cond;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = bus.read & (level_q != '0);
  assign wr_acc = bus.write & ((level_q != LW'(DEPTH)) | rd_acc);

  // Next-state for pointers, level and strobe.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    level_d = level_q;
    stb_d   = rd_acc;
    if (wr_acc) head_d = head_q + AW'(1);
    if (rd_acc) tail_d = tail_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset overrides any same-cycle request.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      level_q <= '0;
      stb_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      stb_q   <= stb_d;
    end
  end

  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (head_q),
    .wdata_i (bus.din),
    .re_i    (rd_acc & ~rst),
    .raddr_i (tail_q),
    .rdata_o (bus.dout)
  );

  // Flag decode from the registered level only.
  always_comb begin
    cond = COND_PARTIAL;
    if (level_q == '0)               cond = COND_EMPTY;
    else if (level_q == LW'(DEPTH))  cond = COND_FULL;
  end

  assign bus.condition    = cond;
  assign bus.level        = level_q;
  assign bus.read_stb     = stb_q;
  assign bus.almost_full  = (level_q >= LW'(AF_LEVEL));
  assign bus.almost_empty = (level_q <= LW'(AE_LEVEL));

`ifdef FIFO_SYNC_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; clear wins over a same-cycle set.
  always_comb begin
    ovf_d = ovf_q | (bus.write & ~wr_acc);
    unf_d = unf_q | (bus.read & ~rd_acc);
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  // Error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param with WIDTH=8, DEPTH=4, AF_LEVEL=2, AE_LEVEL=1.
// FIFO_SYNC_ERR_FLAGS_EN adds checks of the overflow/underflow flags.
module tb_fifo_sync_param;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fifo_sync_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(2), .AE_LEVEL(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
    bus.write = wr;
    bus.read  = rd;
    bus.din   = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0);
  endtask

  task automatic chk_level(input string name, input logic [LW-1:0] exp);
    checks++;
    if (bus.level !== exp) begin
      errors++;
      $display("FAIL %s level: got %0d expected %0d", name, bus.level, exp);
    end
  endtask

  task automatic chk_stb(input string name, input logic exp);
    checks++;
    if (bus.read_stb !== exp) begin
      errors++;
      $display("FAIL %s read_stb: got %0b expected %0b", name, bus.read_stb, exp);
    end
  endtask

  task automatic chk_dout(input string name, input logic [WIDTH-1:0] exp);
    checks++;
    if (bus.dout !== exp) begin
      errors++;
      $display("FAIL %s dout: got %02h expected %02h", name, bus.dout, exp);
    end
  endtask

  task automatic chk_cond(input string name, input logic [1:0] exp);
    checks++;
    if (bus.condition !== exp) begin
      errors++;
      $display("FAIL %s condition: got %02b expected %02b", name, bus.condition, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic af, input logic ae);
    checks++;
    if ({bus.almost_full, bus.almost_empty} !== {af, ae}) begin
      errors++;
      $display("FAIL %s af/ae: got %0b%0b expected %0b%0b", name,
               bus.almost_full, bus.almost_empty, af, ae);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    chk_cond("reset", 2'b00);
    chk_level("reset", 0);
    chk_flags("reset", 1'b0, 1'b1);
    chk_stb("reset", 1'b0);
    chk_dout("reset", 8'h00);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b00) begin
      errors++;
      $display("FAIL reset err flags: got %02b expected 00", {bus.overflow, bus.underflow});
    end
    // Read on empty must set underflow.
    drive(1'b0, 1'b1, '0);
    step();
    idle();
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow set: got %0b expected 1", bus.underflow);
    end
    chk_stb("read_empty", 1'b0);
    chk_level("read_empty", 0);
    // Sticky while idle.
    step();
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow sticky: got %0b expected 1", bus.underflow);
    end
    // Clear wins over a same-cycle empty read.
    bus.err_clr = 1'b1;
    drive(1'b0, 1'b1, '0);
    step();
    bus.err_clr = 1'b0;
    idle();
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow clear: got %0b expected 0", bus.underflow);
    end
`else
    drive(1'b0, 1'b1, '0);
    step();
    idle();
    chk_stb("read_empty", 1'b0);
    chk_level("read_empty", 0);
`endif
  endtask

  task automatic test_fill();
    logic [WIDTH-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, words[i]);
      step();
      chk_level("fill", LW'(i + 1));
      chk_flags("fill", (i + 1) >= 2, (i + 1) <= 1);
      chk_cond("fill", (i == 3) ? 2'b11 : 2'b10);
    end
    // Write alone while full is dropped.
    drive(1'b1, 1'b0, 8'h55);
    step();
    idle();
    chk_level("fill_drop", 4);
    chk_cond("fill_drop", 2'b11);
    chk_stb("fill_drop", 1'b0);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow set: got %0b expected 1", bus.overflow);
    end
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow clear: got %0b expected 0", bus.overflow);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, '0);
      step();
      chk_stb("drain", 1'b1);
      chk_dout("drain", words[i]);
      chk_level("drain", LW'(3 - i));
    end
    idle();
    chk_cond("drain_end", 2'b00);
    step();
    chk_stb("drain_hold", 1'b0);
    chk_dout("drain_hold", 8'h44);
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 8'h00);
    step();
    chk_level("wrap_first", 1);
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b1, (i == 10) ? 8'h00 : WIDTH'(i));
      step();
      chk_stb("wrap", 1'b1);
      chk_dout("wrap", WIDTH'(i - 1));
      chk_level("wrap", 1);
    end
    drive(1'b0, 1'b1, '0);
    step();
    idle();
    chk_dout("wrap_tail", 8'h00);
    chk_level("wrap_tail", 0);
  endtask

  task automatic test_boundary();
    logic [WIDTH-1:0] exp [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, exp[i]);
      step();
    end
    chk_cond("bnd_full", 2'b11);
    // Full with read and write: both taken, level unchanged.
    drive(1'b1, 1'b1, 8'hAA);
    step();
    chk_level("bnd_full_rw", 4);
    chk_stb("bnd_full_rw", 1'b1);
    chk_dout("bnd_full_rw", exp[0]);
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 1'b1, '0);
      step();
      chk_stb("bnd_drain", 1'b1);
      chk_dout("bnd_drain", exp[i]);
    end
    chk_level("bnd_drain", 0);
    // Empty with read and write: write only, no bypass.
    drive(1'b1, 1'b1, 8'h5A);
    step();
    idle();
    chk_level("bnd_empty_rw", 1);
    chk_stb("bnd_empty_rw", 1'b0);
    chk_dout("bnd_empty_rw", 8'hAA);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    checks++;
    if ({bus.overflow, bus.underflow} !== 2'b01) begin
      errors++;
      $display("FAIL bnd err flags: got %02b expected 01", {bus.overflow, bus.underflow});
    end
    bus.err_clr = 1'b1;
`endif
    drive(1'b0, 1'b1, '0);
    step();
    idle();
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    bus.err_clr = 1'b0;
`endif
    chk_stb("bnd_pop", 1'b1);
    chk_dout("bnd_pop", 8'h5A);
    chk_level("bnd_pop", 0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, WIDTH'(8'hC0 + i));
      step();
    end
    chk_level("mid_pre", 3);
    // Read accepted the cycle before reset, then reset with read held.
    drive(1'b0, 1'b1, '0);
    step();
    chk_stb("mid_pre_rd", 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    chk_level("mid_rst", 0);
    chk_stb("mid_rst", 1'b0);
    chk_cond("mid_rst", 2'b00);
    chk_dout("mid_rst", 8'h00);
    chk_flags("mid_rst", 1'b0, 1'b1);
  endtask

  initial begin
    idle();
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    bus.err_clr = 1'b0;
`endif
    test_reset();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_boundary();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO. Successor to the fixed 8-bit/256-entry FIFO used in the Trivium data path.
- Generalises data width and depth.
- Reports a true full condition and an exact level.
- Adds almost-full/almost-empty thresholds and well-defined simultaneous read/write at the boundaries.
- Sits between the keystream generator and the byte consumer; keeps the read-strobe output style of the earlier block.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_LEVEL, DEPTH-2, almost_full asserted when level >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserted when level <= AE_LEVEL

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
din  in  WIDTH  write data
write  in  1  write request
read  in  1  read request
dout  out  WIDTH  read data, valid when read_stb=1, held otherwise
read_stb  out  1  one-cycle strobe: dout carries a newly popped word
condition  out  2  00 empty, 10 partial, 11 full (01 unused)
level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
almost_full  out  1  level >= AF_LEVEL
almost_empty  out  1  level <= AE_LEVEL

Behaviour:
- Reset: clk single clock; rst synchronous, active-high, sampled on rising clk edge. On reset:
  - head, tail and level clear to 0; dout=0, read_stb=0.
  - condition=00, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Memory contents are not reset.
- Pointers: head and tail are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. Level is separate, one bit wider.
- Read accept: rd_acc = read & (level != 0).
- Write accept: wr_acc = write & ((level != DEPTH) | rd_acc).
  - Write when full with a simultaneous accepted read: both accepted, level unchanged.
  - Write when empty with a simultaneous read: read rejected, write accepted. No bypass.
- Write: on wr_acc, mem[head] <= din and head increments.
- Read latency 1: on rd_acc, dout <= mem[tail], tail increments, and read_stb=1 in the next cycle. Otherwise read_stb=0 and dout holds.
- Level update:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged on both or neither.
- Flags: condition, almost_full and almost_empty decode combinationally from registered level. No glitch-relevant paths.
- Rejected requests (read when empty, write when full without a read) change no state and are silent, except as described in Optional Feature.
- Reset mid-operation overrides any same-cycle read/write. read_stb is 0 in the cycle after reset even if a read was accepted before it.
- Elaboration errors:
  - DEPTH not a power of two.
  - AF_LEVEL > DEPTH.
  - AE_LEVEL >= DEPTH.

Optional Feature:
Macro: FIFO_SYNC_ERR_FLAGS_EN.
- Defined: extra ports err_clr (in, 1), overflow (out, 1) and underflow (out, 1).
  - overflow sets the cycle after write & ~wr_acc.
  - underflow sets the cycle after read & ~rd_acc.
  - Both are sticky until err_clr=1 or rst; err_clr has priority over a same-cycle set.
- Not defined: these ports and registers do not exist; rejected requests are silent.

Decomposition:
- Package fifo_pkg:
  - cond_t enum {COND_EMPTY=2'b00, COND_PARTIAL=2'b10, COND_FULL=2'b11}.
  - Function for the pointer width, $clog2-based.
- Sub-module fifo_ram:
  - Simple dual-port WIDTH x DEPTH array: write port (we, waddr, wdata); registered read port (re, raddr, rdata).
  - No reset on the array.
  - fifo_sync_param holds pointers, level, flags and strobe.

Test Plan:
1. WIDTH=8, DEPTH=4, after reset: condition=00, level=0, almost_empty=1, read_stb=0, dout=0. Read with empty -> read_stb stays 0, level 0.
2. Write 0x11,0x22,0x33,0x44 on consecutive cycles -> level 1,2,3,4; condition=11 after the 4th; almost_full=1 from level 2 (AF_LEVEL=2). A 5th write of 0x55 alone is dropped, level stays 4.
3. From full, read 4 times back-to-back -> read_stb high on 4 consecutive cycles with dout 0x11,0x22,0x33,0x44; condition=00 afterwards.
4. Wrap-around: push/pop 10 words 0x00..0x09 keeping level<=2 -> output order exact, with pointers wrapping twice.
5. Boundaries:
   - Full plus read&write with din=0xAA -> level stays 4; 0xAA emerges after the 4 older words.
   - Empty plus read&write -> level becomes 1, read_stb=0 next cycle.
6. rst=1 while level=3 and read=1 -> next cycle level=0, read_stb=0, condition=00. With FIFO_SYNC_ERR_FLAGS_EN: read on empty -> underflow=1 next cycle; err_clr -> underflow=0.
